wavelet_pe_ibuff_loader: RTL and testbench
==========================================

WAVELET_PE_IBUFF_LOADER -- requirements
Module: wavelet_pe_ibuff_loader

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, sample word width.
REQ-002 SHALL have parameter IBUFF_CELL_COUNT, default 2048, input buffer depth in words.
REQ-003 SHALL have parameter MAX_FILTER_SIZE, default 16, largest supported filter length.
REQ-004 SHALL have derived parameters FS_WIDTH = $clog2(MAX_FILTER_SIZE) and IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port load_start, input, 1: single-cycle request to begin a load.
REQ-008 SHALL have port load_len, input, IBUFF_ADDR_WIDTH+1: sample count, sampled on load_start.
REQ-009 SHALL have port core_filter_size, input, FS_WIDTH: filter length, sampled on load_start.
REQ-010 SHALL have port load_abort, input, 1: cancel the load in progress.
REQ-011 SHALL have port s_valid, input, 1: upstream sample valid.
REQ-012 SHALL have port s_data, input, INPUT_WIDTH: upstream sample.
REQ-013 SHALL have port s_ready, output, 1: loader accepts a sample.
REQ-014 SHALL have ports ibuff_w_en (output, 1), ibuff_w_addr (output, IBUFF_ADDR_WIDTH) and ibuff_w_data (output, INPUT_WIDTH): the ibuff write port.
REQ-015 SHALL have ports load_busy (output, 1), load_done (output, 1, one-cycle pulse), load_len_err (output, 1, sticky) and loaded_len (output, IBUFF_ADDR_WIDTH+1, number of words written).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, PAD, DONE.
REQ-017 SHALL, in IDLE, on load_start with 1 <= load_len <= IBUFF_CELL_COUNT: latch load_len and core_filter_size, clear load_len_err and loaded_len, and enter LOAD.
REQ-018 SHALL, in IDLE, on load_start with load_len == 0 or load_len > IBUFF_CELL_COUNT: set load_len_err, stay in IDLE, and perform no writes.
REQ-019 SHALL drive s_ready = 1 only in LOAD; a handshake is the cycle with s_valid && s_ready.
REQ-020 SHALL register each handshake so that, in the next cycle, ibuff_w_en = 1, ibuff_w_addr = the write counter, and ibuff_w_data = the accepted s_data (one cycle of latency).
REQ-021 SHALL start the write counter at 0 and increment it by 1 on every write; loaded_len tracks the counter.
REQ-022 SHALL leave LOAD on the handshake of sample number load_len, going to PAD if padding is enabled and core_filter_size > 1, otherwise to DONE.
REQ-023 SHALL hold load_busy = 1 in LOAD and PAD and for the cycle in which the final write is presented.
REQ-024 SHALL pulse load_done for exactly one cycle, the cycle after the final write, and then return to IDLE.
REQ-025 SHALL ignore load_start while not in IDLE.
REQ-026 SHALL, on load_abort in LOAD or PAD, return to IDLE next cycle: suppress the pending write, produce no load_done, and keep loaded_len.
REQ-027 SHALL give load_abort priority when load_abort and a handshake occur in the same cycle.
REQ-028 SHALL never let the write counter exceed IBUFF_CELL_COUNT-1 and never wrap it.

Reset
REQ-029 SHALL, on rst, asynchronously force state IDLE and set every output to 0: s_ready, ibuff_w_en, ibuff_w_addr, ibuff_w_data, load_busy, load_done, load_len_err, loaded_len.
REQ-030 SHALL, when rst asserts mid-load, discard all progress; no write and no load_done occur after rst is released.

Configuration
REQ-031 SHALL use macro WAVELET_PE_LOADER_PAD_EN to enable tail zero-padding.
REQ-032 SHALL, with WAVELET_PE_LOADER_PAD_EN defined, make PAD write core_filter_size-1 zero words at consecutive addresses, one per cycle with no handshake, stopping early at address IBUFF_CELL_COUNT-1.
REQ-033 SHALL, without WAVELET_PE_LOADER_PAD_EN, remove the PAD state entirely so that LOAD always goes to DONE.

Structure
REQ-034 SHALL place the FSM state enum typedef and the default parameter constants in the shared package wavelet_pe_pkg.
REQ-035 SHALL place the write-address counter (reset, enable, saturation at the last cell) in the sub-module wavelet_pe_addr_counter.

Verification
REQ-036 SHALL cover a basic load: load_len=4, padding off, s_valid held high → writes at addresses 0..3 on cycles 2..5 after start, load_done on cycle 6, loaded_len=4.
REQ-037 SHALL cover a padded load: padding on, load_len=4, filter_size=4 → 4 data writes followed by 3 zero writes at addresses 4..6, loaded_len=7.
REQ-038 SHALL cover invalid lengths: load_len=0, then load_len=IBUFF_CELL_COUNT+1 → load_len_err=1, no ibuff_w_en, load_busy stays 0.
REQ-039 SHALL cover backpressure and abort: s_valid toggling every cycle → one write per handshake; load_abort after 2 handshakes → exactly 2 writes and no load_done.
REQ-040 SHALL cover a full-buffer load: padding on, load_len=IBUFF_CELL_COUNT, filter_size=8 → no pad writes, final address IBUFF_CELL_COUNT-1, load_done pulses.
REQ-041 SHALL cover reset mid-load: rst asserted mid-LOAD → all outputs 0 immediately; a new load_start with load_len=2 then writes addresses 0..1.

Source files
------------

// File: rtl/wavelet_pe_pkg.sv
// Shared constants and FSM state type for the wavelet PE input-buffer loader.
// The PAD state exists only when WAVELET_PE_LOADER_PAD_EN is defined.
package wavelet_pe_pkg;

    localparam int DEFAULT_INPUT_WIDTH      = 32;
    localparam int DEFAULT_IBUFF_CELL_COUNT = 2048;
    localparam int DEFAULT_MAX_FILTER_SIZE  = 16;

`ifdef WAVELET_PE_LOADER_PAD_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } load_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd3
    } load_state_t;
`endif

endpackage

// File: rtl/wavelet_pe_addr_counter.sv
// Input-buffer write-address counter: synchronous clear, count enable,
// holds at the last cell instead of wrapping.
module wavelet_pe_addr_counter #(
    parameter int CELL_COUNT = 2048,
    parameter int ADDR_WIDTH = $clog2(CELL_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELL_COUNT - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST_ADDR)) begin
            count <= count + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wavelet_pe_ibuff_loader.sv
// Streams load_len upstream samples into the PE input buffer with one cycle of write latency.
// Define WAVELET_PE_LOADER_PAD_EN to append core_filter_size-1 zero words after the samples.
module wavelet_pe_ibuff_loader
    import wavelet_pe_pkg::*;
#(
    parameter int INPUT_WIDTH      = DEFAULT_INPUT_WIDTH,
    parameter int IBUFF_CELL_COUNT = DEFAULT_IBUFF_CELL_COUNT,
    parameter int MAX_FILTER_SIZE  = DEFAULT_MAX_FILTER_SIZE,
    parameter int FS_WIDTH         = $clog2(MAX_FILTER_SIZE),
    parameter int IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic [IBUFF_ADDR_WIDTH:0]   load_len,
    input  logic [FS_WIDTH-1:0]         core_filter_size,
    input  logic                        load_abort,
    input  logic                        s_valid,
    input  logic [INPUT_WIDTH-1:0]      s_data,
    output logic                        s_ready,
    output logic                        ibuff_w_en,
    output logic [IBUFF_ADDR_WIDTH-1:0] ibuff_w_addr,
    output logic [INPUT_WIDTH-1:0]      ibuff_w_data,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        load_len_err,
    output logic [IBUFF_ADDR_WIDTH:0]   loaded_len
);

    localparam int                   LEN_WIDTH  = IBUFF_ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] CELLS_LEN  = LEN_WIDTH'(IBUFF_CELL_COUNT);

    load_state_t state, state_next;

    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   acc_cnt;
    logic [LEN_WIDTH-1:0]   loaded_len_q;
    logic [FS_WIDTH-1:0]    fs_q;
    logic                   w_en_q;
    logic [INPUT_WIDTH-1:0] w_data_q;
    logic                   err_q;
    logic                   done_q;

    logic len_ok;
    logic start_ok;
    logic handshake;
    logic last_hs;

    assign len_ok    = (load_len != '0) && (load_len <= CELLS_LEN);
    assign start_ok  = (state == IDLE) && load_start && len_ok;
    assign handshake = s_valid && s_ready;
    assign last_hs   = handshake && ((acc_cnt + LEN_WIDTH'(1)) == len_q);

`ifdef WAVELET_PE_LOADER_PAD_EN
    logic [FS_WIDTH-1:0]  pad_left;
    logic [FS_WIDTH-1:0]  fs_minus1;
    logic [FS_WIDTH-1:0]  pad_count;
    logic [LEN_WIDTH-1:0] room;
    logic                 pad_needed;
    logic                 pad_last;

    // Padding is clipped to the cells left after the samples; a full buffer skips PAD.
    assign fs_minus1  = fs_q - FS_WIDTH'(1);
    assign room       = CELLS_LEN - len_q;
    assign pad_count  = (room < LEN_WIDTH'(fs_minus1)) ? FS_WIDTH'(room) : fs_minus1;
    assign pad_needed = (fs_q > FS_WIDTH'(1)) && (len_q < CELLS_LEN);
    assign pad_last   = (pad_left == FS_WIDTH'(1));
`else
    logic unused_fs;
    assign unused_fs = ^fs_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = LOAD;
            LOAD: begin
                if (load_abort) begin
                    state_next = IDLE;
                end else if (last_hs) begin
`ifdef WAVELET_PE_LOADER_PAD_EN
                    state_next = pad_needed ? PAD : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef WAVELET_PE_LOADER_PAD_EN
            PAD: begin
                if (load_abort) begin
                    state_next = IDLE;
                end else if (pad_last) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // DONE is the cycle the final write is on the port, so it still counts as busy.
    always_comb begin
        s_ready   = 1'b0;
        load_busy = 1'b0;
        case (state)
            LOAD: begin
                s_ready   = 1'b1;
                load_busy = 1'b1;
            end
            IDLE:    load_busy = 1'b0;
            default: load_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            fs_q         <= '0;
            acc_cnt      <= '0;
            loaded_len_q <= '0;
            w_en_q       <= 1'b0;
            w_data_q     <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
`ifdef WAVELET_PE_LOADER_PAD_EN
            pad_left     <= '0;
`endif
        end else begin
            w_en_q <= 1'b0;
            done_q <= (state == DONE);
            if (w_en_q) begin
                loaded_len_q <= loaded_len_q + LEN_WIDTH'(1);
            end
            if ((state == IDLE) && load_start) begin
                if (len_ok) begin
                    len_q        <= load_len;
                    fs_q         <= core_filter_size;
                    acc_cnt      <= '0;
                    loaded_len_q <= '0;
                    err_q        <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            // Abort wins over a same-cycle handshake: the sample is dropped.
            if ((state == LOAD) && handshake && !load_abort) begin
                w_en_q   <= 1'b1;
                w_data_q <= s_data;
                acc_cnt  <= acc_cnt + LEN_WIDTH'(1);
`ifdef WAVELET_PE_LOADER_PAD_EN
                if (last_hs) pad_left <= pad_count;
`endif
            end
`ifdef WAVELET_PE_LOADER_PAD_EN
            if ((state == PAD) && !load_abort) begin
                w_en_q   <= 1'b1;
                w_data_q <= '0;
                pad_left <= pad_left - FS_WIDTH'(1);
            end
`endif
        end
    end

    wavelet_pe_addr_counter #(
        .CELL_COUNT (IBUFF_CELL_COUNT),
        .ADDR_WIDTH (IBUFF_ADDR_WIDTH)
    ) u_addr_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .en    (w_en_q),
        .count (ibuff_w_addr)
    );

    assign ibuff_w_en   = w_en_q;
    assign ibuff_w_data = w_data_q;
    assign load_done    = done_q;
    assign load_len_err = err_q;
    assign loaded_len   = loaded_len_q;

endmodule

// File: tb/tb_wavelet_pe_ibuff_loader.sv
// Self-checking bench for wavelet_pe_ibuff_loader; expected writes come from a list model
// (samples, then clipped zero padding when WAVELET_PE_LOADER_PAD_EN is defined).
module tb_wavelet_pe_ibuff_loader;

    localparam int IW     = 32;
    localparam int CELLS  = 2048;
    localparam int MAX_FS = 16;
    localparam int FSW    = $clog2(MAX_FS);
    localparam int AW     = $clog2(CELLS);
`ifdef WAVELET_PE_LOADER_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic [FSW-1:0] core_filter_size;
    logic          load_abort;
    logic          s_valid;
    logic [IW-1:0] s_data;
    logic          s_ready;
    logic          ibuff_w_en;
    logic [AW-1:0] ibuff_w_addr;
    logic [IW-1:0] ibuff_w_data;
    logic          load_busy;
    logic          load_done;
    logic          load_len_err;
    logic [AW:0]   loaded_len;

    wavelet_pe_ibuff_loader #(
        .INPUT_WIDTH      (IW),
        .IBUFF_CELL_COUNT (CELLS),
        .MAX_FILTER_SIZE  (MAX_FS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .load_len         (load_len),
        .core_filter_size (core_filter_size),
        .load_abort       (load_abort),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .ibuff_w_en       (ibuff_w_en),
        .ibuff_w_addr     (ibuff_w_addr),
        .ibuff_w_data     (ibuff_w_data),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .load_len_err     (load_len_err),
        .loaded_len       (loaded_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write stream and done pulses, sampled on the falling edge.
    int            mon_addr[$];
    logic [IW-1:0] mon_data[$];
    int            mon_cyc[$];
    int            done_count = 0;
    int            done_cyc   = -1;
    int            busy_gap   = 0;
    bit            busy_seen  = 1'b0;

    always @(negedge clk) begin
        if (ibuff_w_en) begin
            mon_addr.push_back(int'(ibuff_w_addr));
            mon_data.push_back(ibuff_w_data);
            mon_cyc.push_back(cyc);
            if (!load_busy) busy_gap++;
        end
        if (load_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (load_busy) busy_seen = 1'b1;
    end

    int            exp_addr[$];
    logic [IW-1:0] exp_data[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        done_count = 0;
        done_cyc   = -1;
        busy_gap   = 0;
        busy_seen  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},    s_ready,      0);
        check({tag, "_w_en"},       ibuff_w_en,   0);
        check({tag, "_w_addr"},     ibuff_w_addr, 0);
        check({tag, "_w_data"},     ibuff_w_data, 0);
        check({tag, "_busy"},       load_busy,    0);
        check({tag, "_done"},       load_done,    0);
        check({tag, "_len_err"},    load_len_err, 0);
        check({tag, "_loaded_len"}, loaded_len,   0);
    endtask

    // vmode: 0 = s_valid always high, 1 = toggling, 2 = random.
    // abort_after >= 0 raises load_abort once that many samples were accepted.
    // poke_start pulses an invalid load_start mid-load, which must be ignored.
    task automatic run_load(input string tag, input int len, input int fs, input int vmode,
                            input int abort_after, input bit poke_start);
        int hs = 0;
        int steps = 0;
        int start_cyc;
        int mism = 0;
        bit aborted = 1'b0;
        bit vld;
        clear_mon();
        exp_addr.delete();
        exp_data.delete();
        load_start       = 1'b1;
        load_len         = (AW+1)'(len);
        core_filter_size = FSW'(fs);
        start_cyc        = cyc;
        @(negedge clk);
        load_start = 1'b0;
        while (hs < len && !aborted && steps < 8 * len + 32) begin
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = (steps % 2 == 0);
                default: vld = ($urandom_range(0, 1) == 1);
            endcase
            s_valid = vld;
            s_data  = $urandom;
            if (poke_start && steps == 2) begin
                load_start = 1'b1;
                load_len   = '0;
            end
            if (abort_after >= 0 && hs == abort_after) begin
                load_abort = 1'b1;
                aborted    = 1'b1;
            end else if (vld && s_ready) begin
                exp_addr.push_back(hs);
                exp_data.push_back(s_data);
                hs++;
            end
            @(negedge clk);
            steps++;
            load_abort = 1'b0;
            load_start = 1'b0;
        end
        s_valid = 1'b0;
        if (abort_after < 0) check({tag, "_accepted"}, hs, len);
        if (!aborted && PAD_ON && fs > 1) begin
            for (int j = 0; j < fs - 1 && len + j < CELLS; j++) begin
                exp_addr.push_back(len + j);
                exp_data.push_back('0);
            end
        end
        repeat (MAX_FS + 4) @(negedge clk);

        check({tag, "_write_count"}, mon_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
            if (mon_addr[i] != exp_addr[i] || mon_data[i] !== exp_data[i]) mism++;
        end
        check({tag, "_write_contents"}, mism, 0);
        check({tag, "_loaded_len"}, loaded_len, exp_addr.size());
        check({tag, "_done_count"}, done_count, aborted ? 0 : 1);
        check({tag, "_busy_on_writes"}, busy_gap, 0);
        check({tag, "_busy_after"}, load_busy, 0);
        check({tag, "_len_err"}, load_len_err, 0);
        if (!aborted && mon_cyc.size() > 0)
            check({tag, "_done_after_last_write"}, done_cyc, mon_cyc[$] + 1);
        if (!aborted && vmode == 0 && mon_cyc.size() > 0) begin
            check({tag, "_first_write_latency"}, mon_cyc[0] - start_cyc, 2);
            check({tag, "_done_latency"}, done_cyc - start_cyc, exp_addr.size() + 2);
        end
    endtask

    task automatic bad_start(input string tag, input int len);
        clear_mon();
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        @(negedge clk);
        load_start = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_len_err"}, load_len_err, 1);
        check({tag, "_writes"}, mon_addr.size(), 0);
        check({tag, "_busy_seen"}, busy_seen, 0);
    endtask

    initial begin
        rst              = 1'b1;
        load_start       = 1'b0;
        load_len         = '0;
        core_filter_size = '0;
        load_abort       = 1'b0;
        s_valid          = 1'b0;
        s_data           = '0;

        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_load("basic", 4, 1, 0, -1, 1'b1);
        run_load("padded", 4, 4, 0, -1, 1'b0);
        bad_start("len_zero", 0);
        run_load("toggle", 7, 5, 1, -1, 1'b0);
        bad_start("len_over", CELLS + 1);
        run_load("abort_toggle", 10, 3, 1, 2, 1'b0);
        run_load("abort_collide", 10, 3, 0, 3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_load($sformatf("rand%0d", k), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, MAX_FS - 1)), 2, -1, 1'b0);
        end
        run_load("near_full", CELLS - 2, 8, 0, -1, 1'b0);
        run_load("full", CELLS, 8, 0, -1, 1'b0);
        check("full_last_addr", (mon_addr.size() > 0) ? mon_addr[$] : -1, CELLS - 1);

        // Reset in the middle of a load.
        clear_mon();
        load_start       = 1'b1;
        load_len         = (AW+1)'(100);
        core_filter_size = FSW'(3);
        @(negedge clk);
        load_start = 1'b0;
        s_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = $urandom | 32'h1;
            @(negedge clk);
        end
        check("midload_writing", ibuff_w_en, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midload_rst");
        @(negedge clk);
        s_valid = 1'b0;
        clear_mon();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_writes", mon_addr.size(), 0);
        check("post_rst_done", done_count, 0);
        run_load("after_rst", 2, 1, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
